// File: rtl/so_ml_pkg.sv
// Shared SO_ML definitions: default coefficient-ROM geometry, the row-fetch
// state encoding and the fixed row map of the coefficient ROM.
package so_ml_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_DEPTH = 37;
  localparam int DEF_COLL  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD
  } fetch_state_e;

  localparam int ROW_VA1    = 0;
  localparam int ROW_A2B1   = 1;
  localparam int ROW_B2BV   = 2;
  localparam int ROW_S_BASE = 3;
  localparam int ROW_BS0    = 35;
  localparam int ROW_BS1    = 36;

  // S_k occupies two consecutive rows: real part first, imaginary part next.
  function automatic int row_s_real(input int k);
    return ROW_S_BASE + 2 * (k - 1);
  endfunction

  function automatic int row_s_imag(input int k);
    return ROW_S_BASE + 2 * (k - 1) + 1;
  endfunction

endpackage

// File: rtl/rom_row_fetch_if.sv
// Row-request, ROM-address and packed-row handshake bundle of rom_row_fetch.
// master = the fetcher, slave = control FSM / ROM / datapath around it.
interface rom_row_fetch_if
  import so_ml_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int COLL      = DEF_COLL,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int COLL_LOG  = $clog2(COLL)
);

  logic                  req_valid;
  logic                  req_ready;
  logic [DEPTH_LOG-1:0]  req_row;
  logic [DEPTH_LOG-1:0]  rom_row;
  logic [COLL_LOG-1:0]   rom_collum;
  logic [WIDTH-1:0]      rom_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH*COLL-1:0] out_data;
  logic [DEPTH_LOG-1:0]  out_row;
  logic                  out_err;

  modport master (
    input  req_valid, req_row, rom_data, out_ready,
    output req_ready, rom_row, rom_collum, out_valid, out_data, out_row, out_err
  );

  modport slave (
    output req_valid, req_row, rom_data, out_ready,
    input  req_ready, rom_row, rom_collum, out_valid, out_data, out_row, out_err
  );

endinterface

// File: rtl/rom_row_fetch.sv
// Turns one row request into a packed row of COLL coefficients by walking the
// column address of a 1-cycle registered coefficient ROM.
module rom_row_fetch
  import so_ml_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int COLL      = DEF_COLL,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int COLL_LOG  = $clog2(COLL)
) (
  input logic             clk,
  input logic             rst_n,
  rom_row_fetch_if.master bus
);

  localparam logic [COLL_LOG-1:0] LAST_COL = COLL_LOG'(COLL - 1);

  fetch_state_e          state_q, state_d;
  logic [DEPTH_LOG-1:0]  rom_row_q, rom_row_d;
  logic [COLL_LOG-1:0]   col_q, col_d;
  logic [COLL_LOG-1:0]   cap_q, cap_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH*COLL-1:0] out_data_q, out_data_d;
  logic [DEPTH_LOG-1:0]  out_row_q, out_row_d;
  logic                  out_err_q, out_err_d;
  logic                  capture;

  always_comb begin
    state_d     = state_q;
    rom_row_d   = rom_row_q;
    col_d       = col_q;
    cap_d       = cap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_err_d   = out_err_q;
    capture     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          out_row_d  = bus.req_row;
          out_data_d = '0;
          cap_d      = '0;
          if (int'(bus.req_row) < DEPTH) begin
            rom_row_d = bus.req_row;
            col_d     = '0;
            out_err_d = 1'b0;
            state_d   = ST_FETCH;
          end else begin
            out_err_d = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_FETCH: begin
        // ROM data trails the address by one cycle, so column 0 has nothing to capture yet.
        capture = (col_q != '0);
        if (capture) cap_d = cap_q + 1'b1;
        if (col_q == LAST_COL) state_d = ST_DRAIN;
        else                   col_d   = col_q + 1'b1;
      end
      ST_DRAIN: begin
        capture     = 1'b1;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        // Out-of-range requests enter HOLD with out_valid low; it rises one cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      for (int unsigned c = 0; c < COLL; c++) begin
        if (cap_q == COLL_LOG'(c)) out_data_d[c*WIDTH +: WIDTH] = bus.rom_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rom_row_q   <= '0;
      col_q       <= '0;
      cap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_row_q   <= rom_row_d;
      col_q       <= col_d;
      cap_q       <= cap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.rom_row    = rom_row_q;
  assign bus.rom_collum = col_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_err    = out_err_q;

endmodule
